systolic_pe_gen: RTL and testbench

SYSTOLIC_PE_GEN -- requirements
Module: systolic_pe_gen

---
 rtl/systolic_pe_gen.sv | 232 +++++++++++++++++++++++
 tb/tb_systolic_pe_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_gen.sv
// -----------------------------------------------------------------------------
// systolic_pe_gen
//
// One processing element of a tapped accumulator. Each accepted sample is
// multiplied by the coefficient chosen by its position in the frame, the
// product is scaled down by FRAC fractional bits and saturated, and the result
// is folded into a running sum. When the last tap of a frame is accumulated,
// out_valid pulses for one cycle alongside the finished sum.
//
// The multiply is a sequential shift-add over WORDLENGTH cycles (MULT), then a
// single ACC cycle commits the result. Accepting a sample therefore makes the
// block busy for WORDLENGTH+1 cycles.
//
// Ports
//   clk30x       in   1     sole clock, rising edge
//   reset        in   1     synchronous, active-high
//   inputword    in   W     signed sample
//   in_valid     in   1     sample offered
//   in_ready     out  1     block is idle and can take a sample
//   start_index  in   IDXW  word index at which the frame begins (tap 0)
//   coeff_we     in   1     coefficient write strobe
//   coeff_addr   in   IDXW  coefficient write address
//   coeff_data   in   W     signed coefficient
//   outputword   out  W     running accumulated value (held between updates)
//   out_valid    out  1     one-cycle pulse marking a completed frame
//   busy         out  1     multiply or accumulate in progress
//   dbg_state_o  out  2     current FSM state (IDLE=0, MULT=1, ACC=2)
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE and does not depend on in_valid. While busy,
// in_valid is ignored; the offered sample is not consumed and nothing about
// it is remembered, so the source must keep offering it until a transfer.
// -----------------------------------------------------------------------------
module systolic_pe_gen #(
   parameter int WORDLENGTH = 16,
   parameter int IDXW       = 3,
   parameter int FRAC       = 14
) (
   input  logic                  clk30x,
   input  logic                  reset,
   input  logic [WORDLENGTH-1:0] inputword,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IDXW-1:0]       start_index,
   input  logic                  coeff_we,
   input  logic [IDXW-1:0]       coeff_addr,
   input  logic [WORDLENGTH-1:0] coeff_data,
   output logic [WORDLENGTH-1:0] outputword,
   output logic                  out_valid,
   output logic                  busy,
   output logic [1:0]            dbg_state_o
);

   localparam int NTAPS = 1 << IDXW;
   localparam int PW    = 2 * WORDLENGTH;
   localparam int CW    = (WORDLENGTH > 1) ? $clog2(WORDLENGTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MULT = 2'd1;
   localparam logic [1:0] ST_ACC  = 2'd2;

   localparam logic [CW-1:0] CNT_LAST = CW'(WORDLENGTH - 1);

   // Saturation limits expressed at product width so the scaled product can
   // be compared directly.
   localparam logic signed [PW-1:0] PMAX = {{(WORDLENGTH+1){1'b0}}, {(WORDLENGTH-1){1'b1}}};
   localparam logic signed [PW-1:0] PMIN = {{(WORDLENGTH+1){1'b1}}, {(WORDLENGTH-1){1'b0}}};

   localparam logic [WORDLENGTH-1:0] WMAX = {1'b0, {(WORDLENGTH-1){1'b1}}};
   localparam logic [WORDLENGTH-1:0] WMIN = {1'b1, {(WORDLENGTH-1){1'b0}}};

   // --------------------------------------------------------------------------
   // State and datapath registers
   // --------------------------------------------------------------------------
   logic [1:0]            state_q,  state_d;
   logic [IDXW-1:0]       wi_q,     wi_d;      // word index within the frame
   logic [IDXW-1:0]       sidx_q,   sidx_d;    // start_index latched at accept
   logic [PW-1:0]         mcand_q,  mcand_d;   // sample, shifted left per step
   logic [WORDLENGTH-1:0] mplier_q, mplier_d;  // coefficient, shifted right
   logic [PW-1:0]         prod_q,   prod_d;    // partial product
   logic [CW-1:0]         cnt_q,    cnt_d;     // multiply step counter
   logic [WORDLENGTH-1:0] acc_q,    acc_d;     // running sum, drives outputword
   logic                  ov_q,     ov_d;

   logic [WORDLENGTH-1:0] coeff_q [NTAPS];

   // --------------------------------------------------------------------------
   // Combinational helpers
   // --------------------------------------------------------------------------
   logic [IDXW-1:0]         accept_pos;  // tap position of the sample on offer
   logic [IDXW-1:0]         pos;         // tap position of the in-flight sample
   logic signed [PW-1:0]    prod_scaled;
   logic [WORDLENGTH-1:0]   prod_sat;
   logic signed [WORDLENGTH:0] sum_ext;
   logic [WORDLENGTH-1:0]   sum_sat;
   logic [WORDLENGTH-1:0]   acc_next;

   // Position is taken modulo NTAPS by the natural wrap of IDXW-bit arithmetic.
   assign accept_pos = wi_q - start_index;
   // wi_q does not move between acceptance and ACC, so the in-flight
   // position can be rebuilt from the latched start index.
   assign pos        = wi_q - sidx_q;

   // Arithmetic right shift floors towards minus infinity.
   assign prod_scaled = $signed(prod_q) >>> FRAC;

   always_comb begin
      prod_sat = prod_scaled[WORDLENGTH-1:0];
      if (prod_scaled > PMAX) begin
         prod_sat = WMAX;
      end else if (prod_scaled < PMIN) begin
         prod_sat = WMIN;
      end
   end

   // One guard bit is enough to detect overflow of a W-bit signed add.
   assign sum_ext = $signed({acc_q[WORDLENGTH-1], acc_q}) +
                    $signed({prod_sat[WORDLENGTH-1], prod_sat});

   always_comb begin
      sum_sat = sum_ext[WORDLENGTH-1:0];
      if (sum_ext[WORDLENGTH] != sum_ext[WORDLENGTH-1]) begin
         sum_sat = sum_ext[WORDLENGTH] ? WMIN : WMAX;
      end
   end

   // Tap 0 opens a new frame, so the previous sum is discarded there.
   assign acc_next = (pos == '0) ? prod_sat : sum_sat;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      wi_d     = wi_q;
      sidx_d   = sidx_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      ov_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d  = ST_MULT;
               sidx_d   = start_index;
               mcand_d  = {{WORDLENGTH{inputword[WORDLENGTH-1]}}, inputword};
               // Coefficient is captured here so later writes cannot disturb
               // the product already under way.
               mplier_d = coeff_q[accept_pos];
               prod_d   = '0;
               cnt_d    = '0;
            end
         end

         ST_MULT: begin
            // Two's complement multiplier: the top bit carries weight
            // -2^(W-1), so its partial product is subtracted.
            if (mplier_q[0]) begin
               if (cnt_q == CNT_LAST) begin
                  prod_d = prod_q - mcand_q;
               end else begin
                  prod_d = prod_q + mcand_q;
               end
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_ACC;
            end
         end

         ST_ACC: begin
            acc_d   = acc_next;
            ov_d    = (pos == {IDXW{1'b1}});
            wi_d    = wi_q + IDXW'(1);
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk30x) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wi_q     <= '0;
         acc_q    <= '0;
         ov_q     <= 1'b0;
         sidx_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wi_q     <= wi_d;
         acc_q    <= acc_d;
         ov_q     <= ov_d;
         sidx_q   <= sidx_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
      end
   end

   // Coefficients survive reset; reset only blocks a write in the same cycle.
   always_ff @(posedge clk30x) begin
      if (!reset && coeff_we) begin
         coeff_q[coeff_addr] <= coeff_data;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign in_ready    = (state_q == ST_IDLE);
   assign busy        = !in_ready;
   assign outputword  = acc_q;
   assign out_valid   = ov_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_systolic_pe_gen.sv
// -----------------------------------------------------------------------------
// tb_systolic_pe_gen
//
// Bench for systolic_pe_gen at W=16, IDXW=3, FRAC=14. A behavioural model
// tracks what the block must show each cycle (accumulated value, frame pulse,
// ready/busy) from acceptance times and plain integer arithmetic; a compare
// process checks the DUT against it on every falling edge, and a queue of
// expected frame results is checked whenever out_valid pulses. Directed
// scenarios add hand-computed literal expectations, then a randomized phase
// mixes samples, coefficient writes, start-index changes and resets.
// -----------------------------------------------------------------------------
module tb_systolic_pe_gen;

   localparam int W    = 16;
   localparam int IDXW = 3;
   localparam int FRAC = 14;
   localparam int NT   = 8;

   // ---------------------------------------------------------------- clock/reset
   logic            clk30x = 1'b0;
   logic            reset  = 1'b1;
   logic [W-1:0]    inputword = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [IDXW-1:0] start_index = '0;
   logic            coeff_we = 1'b0;
   logic [IDXW-1:0] coeff_addr = '0;
   logic [W-1:0]    coeff_data = '0;
   logic [W-1:0]    outputword;
   logic            out_valid;
   logic            busy;
   logic [1:0]      dbg_state;

   always #5 clk30x = ~clk30x;

   systolic_pe_gen #(.WORDLENGTH(W), .IDXW(IDXW), .FRAC(FRAC)) dut (
      .clk30x      (clk30x),
      .reset       (reset),
      .inputword   (inputword),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .start_index (start_index),
      .coeff_we    (coeff_we),
      .coeff_addr  (coeff_addr),
      .coeff_data  (coeff_data),
      .outputword  (outputword),
      .out_valid   (out_valid),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   // ---------------------------------------------------------------- counters
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint sat(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // ---------------------------------------------------------------- model
   longint       m_c [NT];
   int           m_wi;
   longint       m_acc;
   longint       m_out;
   bit           m_ov;
   bit           m_rdy;
   int           m_left;    // cycles until the in-flight result lands
   longint       m_pend;
   bit           m_pend_ov;
   int           m_pos;
   longint       m_prod;
   bit           live = 1'b0;

   logic [W-1:0] exp_q  [$];  // expected value at each out_valid pulse
   logic [W-1:0] seen_q [$];  // values the DUT showed at out_valid pulses

   always @(posedge clk30x) begin
      if (reset) begin
         live   = 1'b1;
         m_wi   = 0;
         m_acc  = 0;
         m_out  = 0;
         m_ov   = 1'b0;
         m_rdy  = 1'b1;
         m_left = 0;
      end else if (live) begin
         m_ov = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_out = m_pend;
               m_acc = m_pend;
               m_ov  = m_pend_ov;
               m_rdy = 1'b1;
               m_wi  = (m_wi + 1) % NT;
               if (m_pend_ov) exp_q.push_back(W'(m_pend));
            end
         end else if (in_valid) begin
            m_pos     = (m_wi - int'(start_index) + NT) % NT;
            m_prod    = longint'($signed(inputword)) * m_c[m_pos];
            m_pend    = sat(m_prod >>> FRAC);
            if (m_pos != 0) m_pend = sat(m_acc + m_pend);
            m_pend_ov = (m_pos == NT - 1);
            m_left    = W + 1;
            m_rdy     = 1'b0;
         end
         if (coeff_we) m_c[coeff_addr] = longint'($signed(coeff_data));
      end
   end

   // ---------------------------------------------------------------- compare
   always @(negedge clk30x) begin
      if (live) begin
         chk("outputword", longint'($signed(outputword)), m_out);
         chk("out_valid",  longint'(out_valid), longint'(m_ov));
         chk("in_ready",   longint'(in_ready),  longint'(m_rdy));
         chk("busy",       longint'(busy),      longint'(!m_rdy));
         if (out_valid) begin
            chk("sb_nonempty", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0)
               chk("sb_frame", longint'($signed(outputword)), longint'($signed(exp_q.pop_front())));
            seen_q.push_back(outputword);
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 60) begin
         @(negedge clk30x);
         n++;
      end
      chk("ready_wait", longint'(in_ready), 1);
   endtask

   task automatic send(input logic [W-1:0] word, input logic [IDXW-1:0] sidx,
                       output int lowcnt);
      wait_ready();
      inputword   = word;
      start_index = sidx;
      in_valid    = 1'b1;
      @(negedge clk30x);
      in_valid = 1'b0;
      lowcnt   = 0;
      while (!in_ready && lowcnt < 60) begin
         lowcnt++;
         @(negedge clk30x);
      end
   endtask

   task automatic wcoef(input int addr, input logic [W-1:0] data);
      coeff_we   = 1'b1;
      coeff_addr = IDXW'(addr);
      coeff_data = data;
      @(negedge clk30x);
      coeff_we = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk30x);
      reset = 1'b0;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int lc;
      int acc_t [$];
      int pick;

      // Reset for two cycles, outputs must be at rest.
      @(negedge clk30x);
      do_reset(2);
      chk("rst_outputword", longint'($signed(outputword)), 0);
      chk("rst_out_valid",  longint'(out_valid), 0);
      chk("rst_in_ready",   longint'(in_ready), 1);
      chk("rst_busy",       longint'(busy), 0);

      // Basic frame: unity coefficients, eight samples of 100.
      for (int i = 0; i < NT; i++) wcoef(i, 16'd16384);
      seen_q.delete();
      for (int i = 0; i < NT; i++) begin
         send(16'd100, 3'd0, lc);
         if (i == 0) chk("latency_low_cycles", lc, 17);
      end
      @(negedge clk30x);
      chk("basic_frames", seen_q.size(), 1);
      if (seen_q.size() > 0) chk("basic_sum", longint'($signed(seen_q[0])), 800);

      // Saturation both ways.
      seen_q.delete();
      for (int i = 0; i < NT; i++) send(16'h7FFF, 3'd0, lc);
      for (int i = 0; i < NT; i++) send(16'h8000, 3'd0, lc);
      @(negedge clk30x);
      chk("sat_frames", seen_q.size(), 2);
      if (seen_q.size() > 1) begin
         chk("sat_pos", longint'($signed(seen_q[0])), 32767);
         chk("sat_neg", longint'($signed(seen_q[1])), -32768);
      end

      // Partial first frame with start_index 3.
      do_reset(2);
      wcoef(0, 16'd16384);
      for (int i = 1; i < NT; i++) wcoef(i, 16'd0);
      seen_q.delete();
      for (int i = 1; i <= 11; i++) send(W'(i), 3'd3, lc);
      @(negedge clk30x);
      chk("partial_frames", seen_q.size(), 2);
      if (seen_q.size() > 1) begin
         chk("partial_first",  longint'($signed(seen_q[0])), 0);
         chk("partial_second", longint'($signed(seen_q[1])), 4);
      end

      // Reset in the fifth MULT cycle; coefficients must survive.
      wait_ready();
      inputword   = 16'd500;
      start_index = 3'd0;
      in_valid    = 1'b1;
      @(negedge clk30x);
      in_valid = 1'b0;
      repeat (4) @(negedge clk30x);
      do_reset(1);
      chk("midrst_in_ready",   longint'(in_ready), 1);
      chk("midrst_busy",       longint'(busy), 0);
      chk("midrst_outputword", longint'($signed(outputword)), 0);
      seen_q.delete();
      for (int i = 0; i < NT; i++) send(16'd1000, 3'd0, lc);
      @(negedge clk30x);
      chk("midrst_frames", seen_q.size(), 1);
      if (seen_q.size() > 0) chk("midrst_coef_kept", longint'($signed(seen_q[0])), 1000);

      // in_valid held high; overwrite the in-flight tap coefficient mid-MULT.
      do_reset(2);
      for (int i = 0; i < NT; i++) wcoef(i, 16'd16384);
      inputword   = 16'd1234;
      start_index = 3'd0;
      in_valid    = 1'b1;
      for (int t = 0; t < 80; t++) begin
         if (in_ready) begin
            acc_t.push_back(t);
            if (acc_t.size() == 2) chk("hold_old_coef", longint'($signed(outputword)), 1234);
         end
         coeff_we = 1'b0;
         if (acc_t.size() > 0 && t == acc_t[acc_t.size()-1] + 3) begin
            coeff_we   = 1'b1;
            coeff_addr = IDXW'((acc_t.size() - 1) % NT);
            coeff_data = '0;
         end
         if (t > 0) inputword = W'($urandom);
         @(negedge clk30x);
      end
      in_valid = 1'b0;
      coeff_we = 1'b0;
      chk("hold_accepts", acc_t.size(), 5);
      for (int i = 1; i < acc_t.size(); i++) chk("hold_gap", acc_t[i] - acc_t[i-1], 18);
      wait_ready();

      // Randomized traffic.
      do_reset(2);
      for (int i = 0; i < NT; i++) wcoef(i, W'($urandom));
      for (int t = 0; t < 500; t++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         pick = $urandom_range(0, 7);
         if (pick == 0)      inputword = 16'h7FFF;
         else if (pick == 1) inputword = 16'h8000;
         else                inputword = W'($urandom);
         if ($urandom_range(0, 15) == 0) start_index = IDXW'($urandom_range(0, NT - 1));
         coeff_we = ($urandom_range(0, 5) == 0);
         coeff_addr = IDXW'($urandom_range(0, NT - 1));
         coeff_data = ($urandom_range(0, 3) == 0) ? 16'd16384 : W'($urandom);
         reset = ($urandom_range(0, 199) == 0);
         @(negedge clk30x);
      end
      in_valid = 1'b0;
      coeff_we = 1'b0;
      reset    = 1'b0;
      wait_ready();
      repeat (2) @(negedge clk30x);
      chk("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
